decode_issue_ctrl: RTL and testbench

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

---
 rtl/decode_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: fetch-side instruction buffer feeding a single registered issue slot.
// Optional feature: define DECODE_ILLEGAL_DETECT_EN to drive illegal_o for BAD-format instructions.
module decode_issue_ctrl #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,
    output logic [31:0] imm_instr_o,
    input  logic [31:0] imm_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_instr_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_imm_o,
    output logic [2:0]  ex_fmt_o,
    output logic        illegal_o,
    output logic [15:0] stall_cnt_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = BUF_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_VALID, S_STALL} state_t;

    logic [31:0]      instr_mem [BUF_DEPTH];
    logic [31:0]      pc_mem    [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic             push, pop;
    state_t           state;

    function automatic logic [2:0] decode_fmt(input logic [6:0] opcode);
        case (opcode)
            7'b0110011:                         decode_fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111: decode_fmt = 3'd1;
            7'b0100011:                         decode_fmt = 3'd2;
            7'b1100011:                         decode_fmt = 3'd3;
            7'b0110111, 7'b0010111:             decode_fmt = 3'd4;
            7'b1101111:                         decode_fmt = 3'd5;
            7'b1110011:                         decode_fmt = 3'd6;
            default:                            decode_fmt = 3'd7;
        endcase
    endfunction

    // The slot only pops when it is free or being drained, so a word pushed into
    // an empty buffer is never issued on the same edge.
    assign push = if_valid_i && if_ready_o;
    assign pop  = (count != '0) && ((state == S_IDLE) || ex_ready_i);

    assign imm_instr_o = (count != '0) ? instr_mem[rd_ptr] : 32'h0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            instr_mem[wr_ptr] <= if_instr_i;
            pc_mem[wr_ptr]    <= if_pc_i;
        end
    end

    // Buffer bookkeeping and issue-slot FSM; flush overrides any same-edge push or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            if_ready_o <= 1'b0;
            state      <= S_IDLE;
            ex_valid_o <= 1'b0;
            ex_instr_o <= 32'h0;
            ex_pc_o    <= 32'h0;
            ex_imm_o   <= 32'h0;
            ex_fmt_o   <= 3'd0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            if_ready_o <= 1'b1;
            state      <= S_IDLE;
            ex_valid_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                ex_instr_o <= instr_mem[rd_ptr];
                ex_pc_o    <= pc_mem[rd_ptr];
                ex_imm_o   <= imm_i;
                ex_fmt_o   <= decode_fmt(instr_mem[rd_ptr][6:0]);
            end
            count      <= count_next;
            if_ready_o <= (count_next < DEPTH_C);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state      <= S_VALID;
                        ex_valid_o <= 1'b1;
                    end
                end
                default: begin
                    if (ex_ready_i) begin
                        state      <= pop ? S_VALID : S_IDLE;
                        ex_valid_o <= pop;
                    end else begin
                        state <= S_STALL;
                    end
                end
            endcase
        end
    end

    // Back-pressure counter survives flush so it reflects the whole run since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 16'h0;
        end else if (ex_valid_o && !ex_ready_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'h1;
        end
    end

`ifdef DECODE_ILLEGAL_DETECT_EN
    assign illegal_o = ex_valid_o && (ex_fmt_o == 3'd7);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed scenarios plus a queue-based random reference model.
module tb_decode_issue_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_instr_i = 32'h0;
    logic [31:0] if_pc_i = 32'h0;
    logic        if_ready_o;
    logic [31:0] imm_instr_o;
    logic [31:0] imm_i;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b0;
    logic [31:0] ex_instr_o, ex_pc_o, ex_imm_o;
    logic [2:0]  ex_fmt_o;
    logic        illegal_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DECODE_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    decode_issue_ctrl #(.BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .if_ready_o(if_ready_o), .imm_instr_o(imm_instr_o), .imm_i(imm_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
        .ex_fmt_o(ex_fmt_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Stand-in immediate generator: sign-extended I-type field of the presented word.
    assign imm_i = {{20{imm_instr_o[31]}}, imm_instr_o[31:20]};

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [11:0] f;
        f = w[31:20];
        return 32'(signed'(f));
    endfunction

    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h33) return 3'd0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        if (op == 7'h73) return 3'd6;
        return 3'd7;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [10];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = ops[k];
        return w;
    endfunction

    task automatic test_reset();
        #12;
        n_cmp++; if (if_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_if_ready got %b want 0", if_ready_o); end
        n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ex_valid got %b want 0", ex_valid_o); end
        n_cmp++; if (stall_cnt_o !== 16'h0) begin n_err++; $display("[TB] FAIL reset_stall got %h want 0", stall_cnt_o); end
        n_cmp++; if ({ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o, illegal_o} !== '0) begin n_err++; $display("[TB] FAIL reset_ex_data got %h/%h/%h/%0d/%b want all 0", ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o, illegal_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL reset_release_ready got %b want 1", if_ready_o); end
    endtask

    task automatic test_random(input int ncyc);
        logic [31:0] q_instr [$];
        logic [31:0] q_pc [$];
        bit          m_valid = 1'b0;
        bit          m_ready = 1'b1;
        logic [31:0] m_instr = '0, m_pc = '0, m_imm = '0;
        logic [2:0]  m_fmt = '0;
        int          m_stall = 0;
        bit          push, pop;
        logic [31:0] w, exp_head;
        for (int c = 0; c < ncyc; c++) begin
            exp_head = (q_instr.size() != 0) ? q_instr[0] : 32'h0;
            n_cmp++; if (ex_valid_o !== m_valid) begin n_err++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", c, ex_valid_o, m_valid); end
            n_cmp++; if (if_ready_o !== m_ready) begin n_err++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", c, if_ready_o, m_ready); end
            n_cmp++; if (stall_cnt_o !== 16'(m_stall)) begin n_err++; $display("[TB] FAIL rnd_stall cyc %0d got %0d want %0d", c, stall_cnt_o, m_stall); end
            n_cmp++; if (imm_instr_o !== exp_head) begin n_err++; $display("[TB] FAIL rnd_head cyc %0d got %h want %h", c, imm_instr_o, exp_head); end
            n_cmp++; if (illegal_o !== (ILL_EN && m_valid && m_fmt == 3'd7)) begin n_err++; $display("[TB] FAIL rnd_illegal cyc %0d got %b", c, illegal_o); end
            if (m_valid) begin
                n_cmp++;
                if ({ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o} !== {m_instr, m_pc, m_imm, m_fmt}) begin
                    n_err++;
                    $display("[TB] FAIL rnd_slot cyc %0d got %h/%h/%h/%0d want %h/%h/%h/%0d", c, ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o, m_instr, m_pc, m_imm, m_fmt);
                end
            end

            flush_i    = ($urandom_range(0, 99) < 3);
            if_valid_i = ($urandom_range(0, 9) < 7);
            if_instr_i = rand_instr();
            w          = $urandom();
            if_pc_i    = {w[31:2], 2'b00};
            ex_ready_i = ($urandom_range(0, 9) < 6);

            push = if_valid_i && m_ready;
            pop  = (q_instr.size() != 0) && (!m_valid || ex_ready_i);
            if (m_valid && !ex_ready_i && m_stall < 65535) m_stall++;
            if (flush_i) begin
                q_instr.delete();
                q_pc.delete();
                m_valid = 1'b0;
            end else begin
                if (pop) begin
                    m_instr = q_instr.pop_front();
                    m_pc    = q_pc.pop_front();
                    m_imm   = ref_imm(m_instr);
                    m_fmt   = ref_fmt(m_instr);
                    m_valid = 1'b1;
                end else if (m_valid && ex_ready_i) begin
                    m_valid = 1'b0;
                end
                if (push) begin
                    q_instr.push_back(if_instr_i);
                    q_pc.push_back(if_pc_i);
                end
            end
            m_ready = (q_instr.size() < DEPTH);
            @(negedge clk);
        end
        flush_i    = 1'b1;
        if_valid_i = 1'b0;
        ex_ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_issue();
        ex_ready_i = 1'b1;
        if_valid_i = 1'b1;
        if_instr_i = 32'h00500093;
        if_pc_i    = 32'h0;
        @(negedge clk);
        if_valid_i = 1'b0;
        n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL basic_no_same_edge got %b want 0", ex_valid_o); end
        n_cmp++; if (imm_instr_o !== 32'h00500093) begin n_err++; $display("[TB] FAIL basic_head got %h want 00500093", imm_instr_o); end
        @(negedge clk);
        n_cmp++; if (ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL basic_valid got %b want 1", ex_valid_o); end
        n_cmp++; if (ex_imm_o !== 32'h5) begin n_err++; $display("[TB] FAIL basic_imm got %h want 5", ex_imm_o); end
        n_cmp++; if (ex_fmt_o !== 3'd1) begin n_err++; $display("[TB] FAIL basic_fmt got %0d want 1", ex_fmt_o); end
        n_cmp++; if ({ex_instr_o, ex_pc_o} !== {32'h00500093, 32'h0}) begin n_err++; $display("[TB] FAIL basic_instr_pc got %h/%h", ex_instr_o, ex_pc_o); end
        @(negedge clk);
        n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL basic_drain got %b want 0", ex_valid_o); end
    endtask

    task automatic test_backpressure();
        int          accepted = 0;
        logic [15:0] s0;
        ex_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if_valid_i = 1'b1;
            if_instr_i = 32'h00100013 + (k << 20);
            if_pc_i    = 32'h100 + k * 4;
            if (if_ready_o) accepted++;
            @(negedge clk);
        end
        if_valid_i = 1'b0;
        n_cmp++; if (accepted != 3) begin n_err++; $display("[TB] FAIL bp_accepted got %0d want 3", accepted); end
        n_cmp++; if (if_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready got %b want 0", if_ready_o); end
        s0 = stall_cnt_o;
        repeat (5) @(negedge clk);
        n_cmp++; if ({ex_valid_o, ex_instr_o, ex_pc_o} !== {1'b1, 32'h00100013, 32'h100}) begin n_err++; $display("[TB] FAIL bp_slot_stable got %b/%h/%h", ex_valid_o, ex_instr_o, ex_pc_o); end
        n_cmp++; if (stall_cnt_o !== s0 + 16'd5) begin n_err++; $display("[TB] FAIL bp_stall_count got %0d want %0d", stall_cnt_o, s0 + 16'd5); end
    endtask

    task automatic test_flush();
        flush_i    = 1'b1;
        if_valid_i = 1'b1;
        if_instr_i = 32'h00000033;
        @(negedge clk);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid got %b want 0", ex_valid_o); end
        n_cmp++; if (if_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL flush_ready got %b want 1", if_ready_o); end
        n_cmp++; if (imm_instr_o !== 32'h0) begin n_err++; $display("[TB] FAIL flush_empty got %h want 0", imm_instr_o); end
        ex_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_no_issue got %b want 0", ex_valid_o); end
        end
    endtask

    task automatic test_illegal();
        ex_ready_i = 1'b1;
        if_valid_i = 1'b1;
        if_instr_i = 32'hFFFFFFFF;
        if_pc_i    = 32'h200;
        @(negedge clk);
        if_valid_i = 1'b0;
        ex_ready_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ex_valid_o, ex_fmt_o} !== {1'b1, 3'd7}) begin n_err++; $display("[TB] FAIL ill_fmt got %b/%0d want 1/7", ex_valid_o, ex_fmt_o); end
        n_cmp++; if (illegal_o !== ILL_EN) begin n_err++; $display("[TB] FAIL ill_flag got %b want %b", illegal_o, ILL_EN); end
        ex_ready_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("[TB] FAIL ill_clear got %b want 0", illegal_o); end
    endtask

    task automatic test_stall_saturation();
        ex_ready_i = 1'b1;
        if_valid_i = 1'b1;
        if_instr_i = 32'h00A00113;
        @(negedge clk);
        if_valid_i = 1'b0;
        ex_ready_i = 1'b0;
        repeat (70000) @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 16'hFFFF) begin n_err++; $display("[TB] FAIL sat_value got %h want FFFF", stall_cnt_o); end
        repeat (3) @(negedge clk);
        n_cmp++; if (stall_cnt_o !== 16'hFFFF) begin n_err++; $display("[TB] FAIL sat_no_wrap got %h want FFFF", stall_cnt_o); end
        n_cmp++; if ({ex_valid_o, ex_instr_o} !== {1'b1, 32'h00A00113}) begin n_err++; $display("[TB] FAIL sat_slot got %b/%h", ex_valid_o, ex_instr_o); end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic test_reset_midop();
        ex_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if_valid_i = 1'b1;
            if_instr_i = 32'h00000037 + (k << 12);
            @(negedge clk);
        end
        if_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({if_ready_o, ex_valid_o, illegal_o} !== 3'b000) begin n_err++; $display("[TB] FAIL rst_mid_ctrl got %b%b%b want 000", if_ready_o, ex_valid_o, illegal_o); end
        n_cmp++; if ({ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o} !== '0) begin n_err++; $display("[TB] FAIL rst_mid_data got %h/%h/%h/%0d", ex_instr_o, ex_pc_o, ex_imm_o, ex_fmt_o); end
        n_cmp++; if ({stall_cnt_o, imm_instr_o} !== '0) begin n_err++; $display("[TB] FAIL rst_mid_cnt got %h/%h want 0/0", stall_cnt_o, imm_instr_o); end
        @(negedge clk);
        ex_ready_i = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_ready got %b want 1", if_ready_o); end
        repeat (3) begin
            n_cmp++; if (ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_stale got %b want 0", ex_valid_o); end
            @(negedge clk);
        end
    endtask

    initial begin
        $display("[TB] decode_issue_ctrl bench start, illegal detect=%0b", ILL_EN);
        test_reset();
        test_random(400);
        test_basic_issue();
        test_backpressure();
        test_flush();
        test_illegal();
        test_stall_saturation();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
